// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op-code constants, the
// data-cache controller state encoding, and byte-lane helpers.
package lsu_pkg;

    localparam logic [3:0] OP_LB = 4'd7;
    localparam logic [3:0] OP_LW = 4'd8;
    localparam logic [3:0] OP_SB = 4'd9;
    localparam logic [3:0] OP_SW = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_CHECK  = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_FILL   = 3'd4,
        ST_MEM_WR = 3'd5,
        ST_RESP   = 3'd6
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SW);
    endfunction

    // Byte at lane sel of a 32-bit word (lane 0 = bits 7:0).
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    // One-hot byte enable for lane sel.
    function automatic logic [3:0] byte_en(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, rstn : clock, asynchronous active-low reset
//   inc       : increment request for this cycle
//   count     : current value; sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache sequencing controller. Takes one load/store at a time from the
// LSQ, probes/writes the cache, does write-through stores and single-word
// refills on load misses, and returns one completion per request.
//   req_*   : LSQ request (valid/ready; accepted on an edge where both are 1)
//   cache_* : cache strobe, op, address, write data; hit/rdata one cycle later
//   mem_*   : single-port memory request, held stable until mem_ack
//   cmp_*   : registered completion, meaningful only while cmp_valid=1
//   miss_count : saturating count of load misses
module dcache_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_pc,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [5:0]        req_reg,
    input  logic [3:0]        req_op,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              cache_en,
    output logic [3:0]        cache_op,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wdata,
    input  logic              cache_hit,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cmp_valid,
    output logic [31:0]       cmp_pc,
    output logic [5:0]        cmp_reg,
    output logic [DATA_W-1:0] cmp_data,
    output logic              cmp_store,
    output logic              cmp_err,
    output logic [CNT_W-1:0]  miss_count
);

    state_t            state;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       pc_q;
    logic [5:0]        reg_q;
    logic              cache_en_q;
    logic [3:0]        cache_op_q;
    logic              sb_hit_wr;
    logic              miss_inc;

    // A byte store that hits must update the cache in the same cycle the hit
    // is seen, so this strobe is the one cache output not taken from a flop.
    assign sb_hit_wr  = (state == ST_CHECK) && (op_q == OP_SB) && cache_hit;
    assign cache_en   = cache_en_q | sb_hit_wr;
    assign cache_op   = sb_hit_wr ? OP_SB : cache_op_q;
    assign cache_addr = addr_q;

    assign miss_inc = (state == ST_CHECK) && is_load(op_q) && !cache_hit;

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (miss_inc),
        .count (miss_count)
    );

    // cache_wdata doubles as the store-data latch and the refill word buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            pc_q        <= '0;
            reg_q       <= '0;
            req_ready   <= 1'b0;
            cache_en_q  <= 1'b0;
            cache_op_q  <= '0;
            cache_wdata <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            cmp_valid   <= 1'b0;
            cmp_pc      <= '0;
            cmp_reg     <= '0;
            cmp_data    <= '0;
            cmp_store   <= 1'b0;
            cmp_err     <= 1'b0;
        end else begin
            cmp_valid  <= 1'b0;
            cache_en_q <= 1'b0;
            cache_op_q <= '0;
            req_ready  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        op_q        <= req_op;
                        addr_q      <= req_addr;
                        pc_q        <= req_pc;
                        reg_q       <= req_reg;
                        cache_wdata <= req_wdata;
                        if (is_load(req_op) || is_store(req_op)) begin
                            state      <= ST_LOOKUP;
                            cache_en_q <= 1'b1;
                            // A byte store only probes here; it writes on hit.
                            cache_op_q <= (req_op == OP_SB) ? OP_LB : req_op;
                        end else begin
                            state     <= ST_RESP;
                            cmp_valid <= 1'b1;
                            cmp_pc    <= req_pc;
                            cmp_reg   <= req_reg;
                            cmp_data  <= '0;
                            cmp_store <= 1'b0;
                            cmp_err   <= 1'b1;
                        end
                    end
                end
                ST_LOOKUP: state <= ST_CHECK;
                ST_CHECK: begin
                    mem_addr <= {addr_q[ADDR_W-1:2], 2'b00};
                    if (is_load(op_q)) begin
                        if (cache_hit) begin
                            state     <= ST_RESP;
                            cmp_valid <= 1'b1;
                            cmp_pc    <= pc_q;
                            cmp_reg   <= reg_q;
                            cmp_data  <= (op_q == OP_LW) ? cache_rdata
                                       : {{(DATA_W-8){1'b0}}, cache_rdata[7:0]};
                            cmp_store <= 1'b0;
                            cmp_err   <= 1'b0;
                        end else begin
                            state   <= ST_MEM_RD;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            mem_be  <= 4'b1111;
                        end
                    end else begin
                        state   <= ST_MEM_WR;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                        if (op_q == OP_SB) begin
                            mem_be    <= byte_en(addr_q[1:0]);
                            mem_wdata <= {(DATA_W/8){cache_wdata[7:0]}};
                        end else begin
                            mem_be    <= 4'b1111;
                            mem_wdata <= cache_wdata;
                        end
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ack) begin
                        state       <= ST_FILL;
                        mem_req     <= 1'b0;
                        cache_wdata <= mem_rdata;
                        cache_en_q  <= 1'b1;
                        cache_op_q  <= OP_SW;
                    end
                end
                ST_FILL: begin
                    state     <= ST_RESP;
                    cmp_valid <= 1'b1;
                    cmp_pc    <= pc_q;
                    cmp_reg   <= reg_q;
                    cmp_data  <= (op_q == OP_LW) ? cache_wdata
                               : {{(DATA_W-8){1'b0}}, byte_lane(cache_wdata[31:0], addr_q[1:0])};
                    cmp_store <= 1'b0;
                    cmp_err   <= 1'b0;
                end
                ST_MEM_WR: begin
                    if (mem_ack) begin
                        state     <= ST_RESP;
                        mem_req   <= 1'b0;
                        cmp_valid <= 1'b1;
                        cmp_pc    <= pc_q;
                        cmp_reg   <= reg_q;
                        cmp_data  <= '0;
                        cmp_store <= 1'b1;
                        cmp_err   <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: cache and memory responders backed by word arrays,
// a driver task that predicts each completion from those arrays, and a
// negedge compare process that checks every completion and its timing.
module tb_dcache_ctrl;
    import lsu_pkg::*;

    localparam int K_HIT = 0, K_MISS = 1, K_ST = 2, K_ILL = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_pc = '0, req_addr = '0, req_wdata = '0;
    logic [5:0]  req_reg = '0;
    logic [3:0]  req_op = '0;
    logic        cache_en, cache_hit = 1'b0;
    logic [3:0]  cache_op;
    logic [31:0] cache_addr, cache_wdata, cache_rdata = '0;
    logic        mem_req, mem_we, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_be;
    logic        cmp_valid, cmp_store, cmp_err;
    logic [31:0] cmp_pc, cmp_data;
    logic [5:0]  cmp_reg;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    dcache_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .req_addr(req_addr), .req_reg(req_reg), .req_op(req_op), .req_wdata(req_wdata),
        .cache_en(cache_en), .cache_op(cache_op), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .cmp_valid(cmp_valid), .cmp_pc(cmp_pc), .cmp_reg(cmp_reg), .cmp_data(cmp_data),
        .cmp_store(cmp_store), .cmp_err(cmp_err), .miss_count(miss_count)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // World model: cache contents, memory contents, preloaded memory image.
    logic [31:0] cache_arr[int];
    logic [31:0] mem_arr[int];
    logic [31:0] pre_mem[int];
    int          ack_delay = 1;
    logic [15:0] exp_miss = '0;

    function automatic logic [31:0] mem_word(input int wa);
        if (mem_arr.exists(wa)) return mem_arr[wa];
        if (pre_mem.exists(wa)) return pre_mem[wa];
        return 32'h0;
    endfunction

    // Cache responder: sample mid-cycle, answer just after the next edge.
    logic [31:0] last_cache_wr;
    initial begin
        logic       s_en;
        logic [3:0] s_op;
        logic [31:0] s_addr, s_wd, w;
        int wa;
        forever begin
            @(negedge clk);
            s_en = cache_en; s_op = cache_op; s_addr = cache_addr; s_wd = cache_wdata;
            @(posedge clk);
            #1;
            cache_hit = 1'b0;
            cache_rdata = '0;
            if (s_en && rstn) begin
                wa = int'(s_addr[31:2]);
                case (s_op)
                    OP_LW: if (cache_arr.exists(wa)) begin cache_hit = 1'b1; cache_rdata = cache_arr[wa]; end
                    OP_LB: if (cache_arr.exists(wa)) begin
                        cache_hit = 1'b1;
                        cache_rdata = cache_arr[wa] >> (8 * int'(s_addr[1:0]));
                    end
                    OP_SW: begin cache_arr[wa] = s_wd; last_cache_wr = s_wd; end
                    OP_SB: if (cache_arr.exists(wa)) begin
                        w = cache_arr[wa];
                        w[8*int'(s_addr[1:0]) +: 8] = s_wd[7:0];
                        cache_arr[wa] = w;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Memory responder: ack after ack_delay sampled request cycles.
    logic [31:0] last_mem_addr, last_mem_wdata;
    logic [3:0]  last_mem_be;
    logic        last_mem_we;
    initial begin
        logic s_req, s_ack, s_we;
        logic [31:0] s_addr, s_wd, w;
        logic [3:0] s_be;
        int cnt = 0;
        int wa;
        forever begin
            @(negedge clk);
            s_req = mem_req; s_ack = mem_ack; s_we = mem_we;
            s_addr = mem_addr; s_wd = mem_wdata; s_be = mem_be;
            @(posedge clk);
            #1;
            if (!rstn) begin
                cnt = 0; mem_ack = 1'b0;
            end else if (s_ack) begin
                mem_ack = 1'b0;
            end else if (s_req) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    cnt = 0;
                    mem_ack = 1'b1;
                    wa = int'(s_addr[31:2]);
                    last_mem_addr = s_addr; last_mem_wdata = s_wd;
                    last_mem_be = s_be; last_mem_we = s_we;
                    if (s_we) begin
                        w = mem_word(wa);
                        for (int b = 0; b < 4; b++) if (s_be[b]) w[8*b +: 8] = s_wd[8*b +: 8];
                        mem_arr[wa] = w;
                    end else begin
                        mem_rdata = mem_word(wa);
                    end
                end
            end
        end
    end

    // Expected completions and the compare process.
    logic [71:0] exp_q[$];
    int          exp_kind_q[$];
    int          exp_t_q[$];
    logic [3:0]  cache_op_log[$];
    int          n_mem_cyc = 0;
    int          last_ack = 0;
    logic [31:0] last_cmp_data = '0;

    always @(negedge clk) begin : cmp_proc
        logic [71:0] e;
        int k, t, want;
        if (mem_ack) last_ack = cyc;
        if (cache_en) cache_op_log.push_back(cache_op);
        if (mem_req) n_mem_cyc++;
        if (cmp_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_cmp: got pc %0h want none", cmp_pc);
            end else begin
                e = exp_q.pop_front();
                k = exp_kind_q.pop_front();
                t = exp_t_q.pop_front();
                check("cmp_fields", {cmp_pc, cmp_reg, cmp_data, cmp_store, cmp_err}, e);
                case (k)
                    K_HIT:   want = t + 2;
                    K_MISS:  want = last_ack + 2;
                    K_ST:    want = last_ack + 1;
                    default: want = t;
                endcase
                check("cmp_cycle", 72'(cyc), 72'(want));
                last_cmp_data = cmp_data;
            end
        end
    end

    // Issue one request, predict its completion, wait for it.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc, input logic [5:0] rg, input int delay);
        int wa, kind, guard;
        logic [31:0] word, data;
        logic st, er;
        wa = int'(addr[31:2]);
        data = '0; st = 1'b0; er = 1'b0; kind = K_ILL;
        if (op == OP_LB || op == OP_LW) begin
            if (cache_arr.exists(wa)) begin
                kind = K_HIT; word = cache_arr[wa];
            end else begin
                kind = K_MISS; word = mem_word(wa);
                if (exp_miss != 16'hFFFF) exp_miss++;
            end
            data = (op == OP_LW) ? word : {24'h0, word[8*int'(addr[1:0]) +: 8]};
        end else if (op == OP_SB || op == OP_SW) begin
            kind = K_ST; st = 1'b1;
        end else begin
            er = 1'b1;
        end
        ack_delay = delay;
        req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc; req_reg = rg;
        req_valid = 1'b1;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        if (req_ready !== 1'b1) begin
            check("req_ready_timeout", 72'(req_ready), 72'(1));
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back({pc, rg, data, st, er});
        exp_kind_q.push_back(kind);
        exp_t_q.push_back(cyc + 1);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin @(negedge clk); guard++; end
        if (exp_q.size() != 0) begin
            check("cmp_timeout", 72'(exp_q.size()), 72'(0));
            exp_q.delete(); exp_kind_q.delete(); exp_t_q.delete();
        end
        check("miss_count", 72'(miss_count), 72'(exp_miss));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, mbase, guard;
        pre_mem[32'h2000 >> 2] = 32'h12345678;
        pre_mem[32'h3000 >> 2] = 32'hAABBCCDD;
        pre_mem[32'h4000 >> 2] = 32'h0BADF00D;
        pre_mem[32'h5000 >> 2] = 32'h01020304;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 72'(req_ready), 72'(0));
        check("rst_cache_en", 72'(cache_en), 72'(0));
        check("rst_mem_req", 72'(mem_req), 72'(0));
        check("rst_cmp_valid", 72'(cmp_valid), 72'(0));
        check("rst_miss_count", 72'(miss_count), 72'(0));
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 72'(req_ready), 72'(1));

        // SW then LW hit
        base = cache_op_log.size();
        issue(OP_SW, 32'h100, 32'hDEADBEEF, 32'h1000, 6'd1, 2);
        check("sw_lookup_op", 72'(cache_op_log[base]), 72'(OP_SW));
        check("sw_mem_be", 72'(last_mem_be), 72'(4'b1111));
        check("sw_mem_wdata", 72'(last_mem_wdata), 72'(32'hDEADBEEF));
        check("sw_mem_we", 72'(last_mem_we), 72'(1));
        issue(OP_LW, 32'h100, 32'h0, 32'h1004, 6'd2, 2);
        check("lw_hit_data", 72'(last_cmp_data), 72'(32'hDEADBEEF));
        check("lw_hit_misses", 72'(miss_count), 72'(0));

        // Cold miss and refill
        issue(OP_LW, 32'h2000, 32'h0, 32'h1008, 6'd3, 5);
        check("lw_miss_data", 72'(last_cmp_data), 72'(32'h12345678));
        check("lw_fill_word", 72'(last_cache_wr), 72'(32'h12345678));
        check("lw_miss_count", 72'(miss_count), 72'(1));
        issue(OP_LW, 32'h2000, 32'h0, 32'h100C, 6'd4, 5);

        // Byte load miss, byte store hit, readback
        issue(OP_LB, 32'h3003, 32'h0, 32'h1010, 6'd5, 3);
        check("lb_miss_data", 72'(last_cmp_data), 72'(32'h000000AA));
        check("lb_mem_addr", 72'(last_mem_addr), 72'(32'h3000));
        base = cache_op_log.size();
        issue(OP_SB, 32'h3001, 32'h00000055, 32'h1014, 6'd6, 1);
        check("sb_mem_be", 72'(last_mem_be), 72'(4'b0010));
        check("sb_mem_wdata", 72'(last_mem_wdata), 72'(32'h55555555));
        check("sb_probe_op", 72'(cache_op_log[base]), 72'(OP_LB));
        check("sb_write_op", 72'(cache_op_log[base+1]), 72'(OP_SB));
        issue(OP_LW, 32'h3000, 32'h0, 32'h1018, 6'd7, 1);
        check("sb_readback", 72'(last_cmp_data), 72'(32'hAABB55DD));

        // Illegal op: no cache or memory activity
        base = cache_op_log.size();
        mbase = n_mem_cyc;
        issue(4'd3, 32'h100, 32'h0, 32'h101C, 6'd8, 1);
        check("ill_cache_en", 72'(cache_op_log.size() - base), 72'(0));
        check("ill_mem_req", 72'(n_mem_cyc - mbase), 72'(0));

        // Reset while waiting in the memory read
        ack_delay = 30;
        req_op = OP_LW; req_addr = 32'h4000; req_pc = 32'h1020; req_reg = 6'd9;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (mem_req !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        check("midrst_reached_mem", 72'(mem_req), 72'(1));
        rstn = 1'b0;
        #1;
        check("midrst_mem_req", 72'(mem_req), 72'(0));
        check("midrst_cache_en", 72'(cache_en), 72'(0));
        check("midrst_req_ready", 72'(req_ready), 72'(0));
        check("midrst_miss_count", 72'(miss_count), 72'(0));
        exp_miss = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        issue(OP_LW, 32'h4000, 32'h0, 32'h1024, 6'd10, 2);
        check("postrst_data", 72'(last_cmp_data), 72'(32'h0BADF00D));

        // Saturation of the miss counter
        force dut.u_miss_cnt.count = 16'hFFFF;
        @(negedge clk);
        release dut.u_miss_cnt.count;
        exp_miss = 16'hFFFF;
        @(negedge clk);
        issue(OP_LW, 32'h5000, 32'h0, 32'h1028, 6'd11, 1);
        check("sat_data", 72'(last_cmp_data), 72'(32'h01020304));
        check("sat_count", 72'(miss_count), 72'(16'hFFFF));

        repeat (5) @(negedge clk);
        check("queue_empty", 72'(exp_q.size()), 72'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
